eth_tx_frame_arb: RTL and testbench

//  Frame-level round-robin arbiter that shares one MAC TX AXI-stream FIFO input among N_SRC

---
 rtl/eth_arb_pkg.sv | 13 +
 rtl/axis_skid_buf.sv | 47 ++++
 rtl/eth_tx_frame_arb.sv | 189 ++++++++++++++++++
 tb/tb_eth_tx_frame_arb.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_arb_pkg.sv
// Shared types and constants for the Ethernet TX frame arbiter.
package eth_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        ABORT = 2'd2,
        DRAIN = 2'd3
    } arb_state_t;

    localparam logic [7:0] ABORT_TDATA = 8'h00;

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry AXI-stream skid buffer with registered outputs; the ready towards the
// producer depends only on local state, so 1 beat/cycle flows while out_ready stays high.
module axis_skid_buf #(
    parameter int WIDTH = 10
) (
    input  logic             clk_100,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [WIDTH-1:0] skid_data;
    logic             skid_valid;
    logic             push;

    assign in_ready = !skid_valid;
    assign push     = in_valid && in_ready;

    // Output register refills from the skid slot first, else straight from the input; a beat arriving while the output is stalled parks in the skid slot.
    always_ff @(posedge clk_100) begin
        if (!reset_n) begin
            out_data   <= '0;
            out_valid  <= 1'b0;
            skid_data  <= '0;
            skid_valid <= 1'b0;
        end else if (!out_valid || out_ready) begin
            if (skid_valid) begin
                out_data   <= skid_data;
                out_valid  <= 1'b1;
                skid_valid <= 1'b0;
            end else begin
                out_valid <= push;
                if (push) begin
                    out_data <= in_data;
                end
            end
        end else if (push) begin
            skid_data  <= in_data;
            skid_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/eth_tx_frame_arb.sv
// Frame-level round-robin arbiter feeding the MAC TX FIFO. A grant lasts a whole frame;
// stalled or oversize frames are cut with a bad tail beat and the remainder is drained.
module eth_tx_frame_arb
    import eth_arb_pkg::*;
#(
    parameter int N_SRC      = 2,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_LEN    = 1518,
    parameter int TIMEOUT    = 16
) (
    input  logic                          clk_100,
    input  logic                          reset_n,
    input  logic [N_SRC*DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [N_SRC-1:0]              s_axis_tvalid,
    input  logic [N_SRC-1:0]              s_axis_tlast,
    input  logic [N_SRC-1:0]              s_axis_tuser,
    output logic [N_SRC-1:0]              s_axis_trdy,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic                          m_axis_tvalid,
    output logic                          m_axis_tlast,
    output logic                          m_axis_tuser,
    input  logic                          m_axis_trdy,
    output logic                          grant_vld,
    output logic [$clog2(N_SRC)-1:0]      grant_idx,
    output logic                          abort_pulse
);

    localparam int IDX_W  = $clog2(N_SRC);
    localparam int LEN_W  = $clog2(MAX_LEN + 1);
    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    localparam int BUF_W  = DATA_WIDTH + 2;

    arb_state_t        state_q, state_d;
    logic [IDX_W-1:0]  grant_q, grant_d;
    logic [IDX_W-1:0]  last_q, last_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              abort_q, abort_d;

    logic [DATA_WIDTH-1:0] sel_data;
    logic                  sel_valid;
    logic                  sel_last;
    logic                  sel_user;

    logic                  req_found;
    logic [IDX_W-1:0]      req_idx;

    logic                  push_valid;
    logic [BUF_W-1:0]      push_data;
    logic                  skid_in_ready;
    logic [BUF_W-1:0]      skid_out_data;

    // Select the granted source's stream signals.
    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_user  = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            if (grant_q == IDX_W'(i)) begin
                sel_data  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                sel_valid = s_axis_tvalid[i];
                sel_last  = s_axis_tlast[i];
                sel_user  = s_axis_tuser[i];
            end
        end
    end

    // Round-robin search starting just after the last source to finish a frame.
    always_comb begin
        logic [IDX_W-1:0] cand;
        cand      = '0;
        req_found = 1'b0;
        req_idx   = last_q;
        for (int k = 1; k <= N_SRC; k++) begin
            cand = IDX_W'((int'(last_q) + k) % N_SRC);
            if (!req_found && s_axis_tvalid[cand]) begin
                req_found = 1'b1;
                req_idx   = cand;
            end
        end
    end

    // Next-state, counter and handshake logic; truncation paths rewrite the pushed beat as a bad tail.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        len_d       = len_q;
        idle_d      = idle_q;
        abort_d     = 1'b0;
        push_valid  = 1'b0;
        push_data   = {sel_data, sel_last, sel_user};
        s_axis_trdy = '0;

        case (state_q)
            IDLE: begin
                if (req_found) begin
                    grant_d = req_idx;
                    len_d   = '0;
                    idle_d  = '0;
                    state_d = XFER;
                end
            end

            XFER: begin
                s_axis_trdy[grant_q] = skid_in_ready;
                if (sel_valid && skid_in_ready) begin
                    push_valid = 1'b1;
                    idle_d     = '0;
                    len_d      = len_q + LEN_W'(1);
                    if (sel_last) begin
                        last_d  = grant_q;
                        state_d = IDLE;
                    end else if (len_q >= LEN_W'(MAX_LEN - 1)) begin
                        push_data = {sel_data, 2'b11};
                        abort_d   = 1'b1;
                        state_d   = DRAIN;
                    end
                end else if (!sel_valid) begin
                    if (idle_q >= IDLE_W'(TIMEOUT - 1)) begin
                        abort_d = 1'b1;
                        state_d = ABORT;
                    end else begin
                        idle_d = idle_q + IDLE_W'(1);
                    end
                end
            end

            ABORT: begin
                push_valid = 1'b1;
                push_data  = {DATA_WIDTH'(ABORT_TDATA), 2'b11};
                if (skid_in_ready) begin
                    state_d = DRAIN;
                end
            end

            DRAIN: begin
                s_axis_trdy[grant_q] = 1'b1;
                if (sel_valid && sel_last) begin
                    last_d  = grant_q;
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State, grant, round-robin pointer and counters; the pointer starts at the top so source 0 wins first.
    always_ff @(posedge clk_100) begin
        if (!reset_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= IDX_W'(N_SRC - 1);
            len_q   <= '0;
            idle_q  <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            len_q   <= len_d;
            idle_q  <= idle_d;
            abort_q <= abort_d;
        end
    end

    axis_skid_buf #(
        .WIDTH(BUF_W)
    ) u_skid (
        .clk_100  (clk_100),
        .reset_n  (reset_n),
        .in_data  (push_data),
        .in_valid (push_valid),
        .in_ready (skid_in_ready),
        .out_data (skid_out_data),
        .out_valid(m_axis_tvalid),
        .out_ready(m_axis_trdy)
    );

    assign m_axis_tdata = skid_out_data[BUF_W-1:2];
    assign m_axis_tlast = skid_out_data[1];
    assign m_axis_tuser = skid_out_data[0];
    assign grant_vld    = (state_q != IDLE);
    assign grant_idx    = grant_q;
    assign abort_pulse  = abort_q;

endmodule

// File: tb/tb_eth_tx_frame_arb.sv
// Self-checking bench for eth_tx_frame_arb: frame-level sources and a sink with
// selectable backpressure, compared against a frame-rule reference model.
module tb_eth_tx_frame_arb;

    localparam int N_SRC   = 2;
    localparam int MAX_LEN = 8;
    localparam int TIMEOUT = 16;

    logic        clk_100 = 1'b0;
    logic        reset_n;
    logic [15:0] s_axis_tdata;
    logic [1:0]  s_axis_tvalid;
    logic [1:0]  s_axis_tlast;
    logic [1:0]  s_axis_tuser;
    logic [1:0]  s_axis_trdy;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tuser;
    logic        m_axis_trdy;
    logic        grant_vld;
    logic [0:0]  grant_idx;
    logic        abort_pulse;

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic       user;
        int         gap;
    } beat_t;

    beat_t      src_q[N_SRC][$];
    beat_t      all_beats[$];
    int         fr_off[$];
    int         fr_len[$];
    int         pend[N_SRC][$];
    logic [9:0] exp_q[$];
    logic [9:0] got_q[$];
    int         gap_left[N_SRC];
    logic       fire_prev[N_SRC];

    int   trdy_mode = 0;
    logic toggle_ph = 1'b0;
    int   abort_seen = 0;
    int   exp_abort = 0;
    int   model_last = N_SRC - 1;
    bit   seen_grant = 0;
    int   low_run = 0;
    int   gap_count = 0;
    int   max_gap = 0;
    int   tests_run = 0;
    int   tests_failed = 0;

    always #5 clk_100 = ~clk_100;

    eth_tx_frame_arb #(
        .N_SRC     (N_SRC),
        .DATA_WIDTH(8),
        .MAX_LEN   (MAX_LEN),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk_100      (clk_100),
        .reset_n      (reset_n),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast (s_axis_tlast),
        .s_axis_tuser (s_axis_tuser),
        .s_axis_trdy  (s_axis_trdy),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tuser (m_axis_tuser),
        .m_axis_trdy  (m_axis_trdy),
        .grant_vld    (grant_vld),
        .grant_idx    (grant_idx),
        .abort_pulse  (abort_pulse)
    );

    // Source drivers: present the head beat of each queue, honour per-beat gaps, pop after a handshake.
    initial begin
        beat_t dummy;
        s_axis_tdata  = '0;
        s_axis_tvalid = '0;
        s_axis_tlast  = '0;
        s_axis_tuser  = '0;
        for (int i = 0; i < N_SRC; i++) begin
            gap_left[i]  = 0;
            fire_prev[i] = 1'b0;
        end
        forever begin
            @(negedge clk_100);
            for (int i = 0; i < N_SRC; i++) begin
                if (fire_prev[i]) begin
                    dummy = src_q[i].pop_front();
                    if (src_q[i].size() > 0) gap_left[i] = src_q[i][0].gap;
                end
                if (src_q[i].size() > 0 && gap_left[i] == 0) begin
                    s_axis_tvalid[i]      = 1'b1;
                    s_axis_tdata[8*i +: 8] = src_q[i][0].data;
                    s_axis_tlast[i]       = src_q[i][0].last;
                    s_axis_tuser[i]       = src_q[i][0].user;
                end else begin
                    s_axis_tvalid[i] = 1'b0;
                    s_axis_tlast[i]  = 1'b0;
                    s_axis_tuser[i]  = 1'b0;
                    if (gap_left[i] > 0) gap_left[i]--;
                end
                fire_prev[i] = s_axis_tvalid[i] && s_axis_trdy[i];
            end
        end
    end

    // Sink and monitor: drive m_axis_trdy per mode, capture accepted beats, count abort pulses and grant gaps.
    initial begin
        m_axis_trdy = 1'b0;
        forever begin
            @(negedge clk_100);
            case (trdy_mode)
                0:       m_axis_trdy = 1'b1;
                1:       begin toggle_ph = !toggle_ph; m_axis_trdy = toggle_ph; end
                default: m_axis_trdy = ($urandom_range(0, 1) == 1);
            endcase
            if (m_axis_tvalid && m_axis_trdy) got_q.push_back({m_axis_tdata, m_axis_tlast, m_axis_tuser});
            if (abort_pulse) abort_seen++;
            if (grant_vld) begin
                if (seen_grant && low_run > 0) begin
                    gap_count++;
                    if (low_run > max_gap) max_gap = low_run;
                end
                seen_grant = 1;
                low_run    = 0;
            end else if (seen_grant) begin
                low_run++;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic newStep();
        @(posedge clk_100);
        #2;
        all_beats.delete();
        fr_off.delete();
        fr_len.delete();
        for (int i = 0; i < N_SRC; i++) pend[i].delete();
        exp_q.delete();
        got_q.delete();
        abort_seen = 0;
        exp_abort  = 0;
        seen_grant = 0;
        low_run    = 0;
        gap_count  = 0;
        max_gap    = 0;
    endtask

    // gap_at < 1 means no long stall; jitter adds 0..jitter idle cycles before later beats.
    task automatic addFrame(input int src, input int len, input int gap_at, input int gap_len,
                            input int jitter, input bit counting);
        beat_t bt;
        fr_off.push_back(all_beats.size());
        fr_len.push_back(len);
        pend[src].push_back(fr_len.size() - 1);
        for (int b = 0; b < len; b++) begin
            bt.data = counting ? 8'(8'h11 * (b + 1)) : 8'($urandom);
            bt.last = (b == len - 1);
            bt.user = counting ? 1'b0 : ($urandom_range(0, 7) == 0);
            if (b == 0)           bt.gap = 0;
            else if (b == gap_at) bt.gap = gap_len;
            else                  bt.gap = $urandom_range(0, jitter);
            all_beats.push_back(bt);
            src_q[src].push_back(bt);
        end
    endtask

    function automatic bit anyPending();
        bit p = 0;
        for (int i = 0; i < N_SRC; i++) if (pend[i].size() > 0) p = 1;
        return p;
    endfunction

    // Reference model: round-robin among sources with frames waiting, then per-frame truncation rules.
    task automatic buildExpected();
        int s;
        int fid;
        beat_t bt;
        while (anyPending()) begin
            s = model_last;
            do s = (s + 1) % N_SRC; while (pend[s].size() == 0);
            fid = pend[s].pop_front();
            model_last = s;
            for (int b = 0; b < fr_len[fid]; b++) begin
                bt = all_beats[fr_off[fid] + b];
                if (b > 0 && bt.gap >= TIMEOUT) begin
                    exp_q.push_back({8'h00, 2'b11});
                    exp_abort++;
                    break;
                end
                if (bt.last) begin
                    exp_q.push_back({bt.data, 1'b1, bt.user});
                    break;
                end
                if (b + 1 == MAX_LEN) begin
                    exp_q.push_back({bt.data, 2'b11});
                    exp_abort++;
                    break;
                end
                exp_q.push_back({bt.data, 1'b0, bt.user});
            end
        end
    endtask

    task automatic applyStimulus(input string tag, input int mode);
        bit done = 0;
        int n;
        buildExpected();
        trdy_mode = mode;
        for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
            @(negedge clk_100);
            #1;
            done = (src_q[0].size() == 0) && (src_q[1].size() == 0) && !grant_vld && !m_axis_tvalid;
        end
        checkOutput({tag, "_done"}, 32'(done), 32'd1);
        repeat (2) @(negedge clk_100);
        #1;
        checkOutput({tag, "_nbeats"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            checkOutput($sformatf("%s_beat%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        checkOutput({tag, "_aborts"}, abort_seen, exp_abort);
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_tvalid"}, 32'(m_axis_tvalid), 32'd0);
        checkOutput({tag, "_tdata"},  32'(m_axis_tdata),  32'd0);
        checkOutput({tag, "_tlast"},  32'(m_axis_tlast),  32'd0);
        checkOutput({tag, "_tuser"},  32'(m_axis_tuser),  32'd0);
        checkOutput({tag, "_gvld"},   32'(grant_vld),     32'd0);
        checkOutput({tag, "_gidx"},   32'(grant_idx),     32'd0);
        checkOutput({tag, "_abort"},  32'(abort_pulse),   32'd0);
        checkOutput({tag, "_strdy"},  32'(s_axis_trdy),   32'd0);
    endtask

    // Directed and randomized steps in sequence.
    initial begin
        bit ok;
        int kind, len, src;

        reset_n = 1'b0;
        repeat (3) @(posedge clk_100);
        #2;
        checkIdleOutputs("rst");
        reset_n    = 1'b1;
        model_last = N_SRC - 1;

        // Single counting frame from source 0.
        newStep();
        addFrame(0, 4, -1, 0, 0, 1);
        ok = 0;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clk_100);
            ok = grant_vld;
        end
        checkOutput("t1_granted", 32'(ok), 32'd1);
        checkOutput("t1_grant_idx", 32'(grant_idx), 32'd0);
        applyStimulus("t1", 0);

        // Two continuous sources alternate with one dead cycle between frames.
        newStep();
        for (int f = 0; f < 3; f++) begin
            addFrame(0, 3, -1, 0, 0, 0);
            addFrame(1, 3, -1, 0, 0, 0);
        end
        applyStimulus("t2", 0);
        checkOutput("t2_gaps", gap_count, 5);
        checkOutput("t2_gaplen", max_gap, 1);

        // Source 1 stalls mid-frame long enough to time out.
        newStep();
        addFrame(1, 5, 2, 20, 0, 0);
        addFrame(0, 2, -1, 0, 0, 0);
        addFrame(0, 3, -1, 0, 0, 0);
        applyStimulus("t3", 0);

        // Oversize frame truncated at MAX_LEN, following frame intact.
        newStep();
        addFrame(0, 12, -1, 0, 0, 0);
        addFrame(0, 4, -1, 0, 0, 0);
        applyStimulus("t4", 0);

        // Alternating sink ready.
        newStep();
        addFrame(1, 6, -1, 0, 0, 0);
        applyStimulus("t5", 1);

        // Stall boundary: one cycle short of the timeout, then exactly at it.
        newStep();
        addFrame(0, 4, 2, TIMEOUT - 1, 0, 0);
        addFrame(1, 4, 1, TIMEOUT, 0, 0);
        applyStimulus("tb", 2);

        // Randomized frame mixes under each sink mode.
        for (int r = 0; r < 3; r++) begin
            newStep();
            for (int f = 0; f < 8; f++) begin
                src  = $urandom_range(0, 1);
                kind = $urandom_range(0, 4);
                if (kind == 0) begin
                    addFrame(src, $urandom_range(MAX_LEN + 1, MAX_LEN + 4), -1, 0, 2, 0);
                end else if (kind == 1) begin
                    len = $urandom_range(3, 6);
                    addFrame(src, len, $urandom_range(1, len - 1), 20, 2, 0);
                end else begin
                    addFrame(src, $urandom_range(1, MAX_LEN - 1), -1, 0, 3, 0);
                end
            end
            applyStimulus($sformatf("rnd%0d", r), r);
        end

        // Reset in the middle of a frame, then a clean frame.
        newStep();
        trdy_mode = 0;
        addFrame(0, 7, -1, 0, 0, 0);
        ok = 0;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk_100);
            #1;
            ok = (got_q.size() >= 3);
        end
        checkOutput("t6_midframe", 32'(ok), 32'd1);
        @(posedge clk_100);
        #2;
        reset_n = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            src_q[i].delete();
            gap_left[i]  = 0;
            fire_prev[i] = 1'b0;
        end
        s_axis_tvalid = '0;
        s_axis_tlast  = '0;
        s_axis_tuser  = '0;
        @(posedge clk_100);
        #2;
        reset_n = 1'b1;
        checkIdleOutputs("t6_rst");
        model_last = N_SRC - 1;
        newStep();
        addFrame(0, 5, -1, 0, 0, 0);
        applyStimulus("t6", 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
